bus_request_arbiter: RTL and testbench

BUS_REQUEST_ARBITER -- requirements
Module: bus_request_arbiter

---
 rtl/bus_request_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bus_request_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_request_arbiter.sv
// Round-robin arbiter that grants one of NUM_REQUESTERS L2 ports the shared L3/memory bus.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles.
module bus_request_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQUESTERS-1:0]            req_read,
  input  logic [NUM_REQUESTERS-1:0]            req_write,
  input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_write_data,
  output logic [NUM_REQUESTERS-1:0]            grant,
  output logic [NUM_REQUESTERS-1:0]            done,
  output logic [DATA_WIDTH-1:0]                rsp_read_data,
  output logic                                 bus_read_request,
  output logic                                 bus_write_request,
  output logic [ADDRESS_WIDTH-1:0]             bus_address,
  output logic [DATA_WIDTH-1:0]                bus_write_data,
  input  logic [DATA_WIDTH-1:0]                bus_read_data,
  input  logic                                 bus_ready,
  output logic                                 timeout_error
);
  localparam int unsigned IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                    state, state_next;
  logic [IDX_W-1:0]          last_grant, last_grant_next;
  logic [NUM_REQUESTERS-1:0] grant_next, done_next;
  logic                      bus_read_request_next, bus_write_request_next;
  logic [ADDRESS_WIDTH-1:0]  bus_address_next;
  logic [DATA_WIDTH-1:0]     bus_write_data_next, rsp_read_data_next;

  logic [NUM_REQUESTERS-1:0] req_any, sel_onehot;
  logic                      sel_valid, sel_write;
  logic [IDX_W-1:0]          sel_idx, cand, grant_idx;
  logic [ADDRESS_WIDTH-1:0]  sel_address;
  logic [DATA_WIDTH-1:0]     sel_write_data;

  // The timeout limit only shapes the watchdog; a zero limit is not a usable setting.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_limit_zero
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             timeout_next;
`endif

  assign req_any = req_read | req_write;

  // Round-robin search starting one past the last granted port.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(NUM_REQUESTERS); k++) begin
      cand = IDX_W'((int'(last_grant) + k) % int'(NUM_REQUESTERS));
      if (!sel_valid && req_any[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Winner payload mux and index of the current owner.
  always_comb begin
    sel_onehot     = '0;
    sel_address    = '0;
    sel_write_data = '0;
    sel_write      = 1'b0;
    grant_idx      = '0;
    for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_onehot[i]  = 1'b1;
        sel_address    = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_write_data = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write      = req_write[i];
      end
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_next             = state;
    last_grant_next        = last_grant;
    grant_next             = grant;
    done_next              = '0;
    bus_read_request_next  = 1'b0;
    bus_write_request_next = 1'b0;
    bus_address_next       = bus_address;
    bus_write_data_next    = bus_write_data;
    rsp_read_data_next     = rsp_read_data;
`ifdef ARB_TIMEOUT_EN
    wait_cnt_next          = wait_cnt;
    timeout_next           = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_next             = ISSUE;
          grant_next             = sel_onehot;
          bus_address_next       = sel_address;
          bus_write_data_next    = sel_write_data;
          bus_write_request_next = sel_write;
          bus_read_request_next  = !sel_write;
        end
      end
      ISSUE: begin
        state_next = WAIT;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_next = '0;
`endif
      end
      WAIT: begin
        if (bus_ready) begin
          state_next         = DONE;
          rsp_read_data_next = bus_read_data;
          done_next          = grant;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next         = DONE;
          rsp_read_data_next = '0;
          done_next          = grant;
          timeout_next       = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        state_next      = IDLE;
        last_grant_next = grant_idx;
        grant_next      = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      last_grant        <= IDX_W'(NUM_REQUESTERS - 1);
      grant             <= '0;
      done              <= '0;
      bus_read_request  <= 1'b0;
      bus_write_request <= 1'b0;
      bus_address       <= '0;
      bus_write_data    <= '0;
      rsp_read_data     <= '0;
    end else begin
      state             <= state_next;
      last_grant        <= last_grant_next;
      grant             <= grant_next;
      done              <= done_next;
      bus_read_request  <= bus_read_request_next;
      bus_write_request <= bus_write_request_next;
      bus_address       <= bus_address_next;
      bus_write_data    <= bus_write_data_next;
      rsp_read_data     <= rsp_read_data_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt      <= '0;
      timeout_error <= 1'b0;
    end else begin
      wait_cnt      <= wait_cnt_next;
      timeout_error <= timeout_next;
    end
  end
`else
  assign timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Self-checking bench for bus_request_arbiter: vector table, directed corner sequences
// and a randomized run checked against a transaction-level round-robin model.
module tb_bus_request_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 128;
  localparam int unsigned TMO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_read, req_write;
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_write_data;
  logic [N-1:0]    grant, done;
  logic [DW-1:0]   rsp_read_data, bus_write_data, bus_read_data;
  logic            bus_read_request, bus_write_request, bus_ready, timeout_error;
  logic [AW-1:0]   bus_address;

  int checks = 0;
  int errors = 0;

  bus_request_arbiter #(.NUM_REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                        .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_write_data(req_write_data), .grant(grant), .done(done),
    .rsp_read_data(rsp_read_data), .bus_read_request(bus_read_request),
    .bus_write_request(bus_write_request), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_read_data(bus_read_data), .bus_ready(bus_ready),
    .timeout_error(timeout_error));

  always #5 clk = ~clk;

  // Memory-side responder: answers each strobe after resp_delay extra WAIT cycles.
  logic          resp_en = 1'b0, force_ready = 1'b0, auto_ready = 1'b0, resp_pend = 1'b0;
  int            resp_delay = 0, resp_cd = 0;
  logic [DW-1:0] resp_data = '0, noise = '0;
  assign bus_ready     = auto_ready | force_ready;
  assign bus_read_data = bus_ready ? resp_data : noise;

  always @(negedge clk) begin
    auto_ready = 1'b0;
    noise = {$urandom, $urandom, $urandom, $urandom};
    if (!reset || !resp_en) resp_pend = 1'b0;
    else if (bus_read_request || bus_write_request) begin
      resp_pend = 1'b1;
      resp_cd   = resp_delay + 1;
    end else if (resp_pend) begin
      resp_cd--;
      if (resp_cd == 0) begin
        auto_ready = 1'b1;
        resp_pend  = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0 && i < int'(N)) v[i] = 1'b1;
    return v;
  endfunction

  // Reference round-robin: first requesting port after the last winner, wrapping.
  function automatic int rr_pick(input logic [N-1:0] pend, input int last_g);
    for (int k = 1; k <= int'(N); k++)
      if (pend[(last_g + k) % int'(N)]) return (last_g + k) % int'(N);
    return -1;
  endfunction

  task automatic set_port(input int p, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[p] = rd;
    req_write[p] = wr;
    req_address[p*AW +: AW] = a;
    req_write_data[p*DW +: DW] = d;
  endtask

  task automatic wait_done(input int budget, output logic [N-1:0] dvec, output logic [DW-1:0] rsp,
                           output int lat, output int nrd, output int nwr,
                           output logic [AW-1:0] addr, output logic [DW-1:0] wdata,
                           output logic tmo);
    dvec = '0; rsp = '0; lat = 0; nrd = 0; nwr = 0; addr = '0; wdata = '0; tmo = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus_read_request) nrd++;
      if (bus_write_request) nwr++;
      if (bus_read_request || bus_write_request) begin
        addr = bus_address;
        wdata = bus_write_data;
      end
      if (done != '0) begin
        dvec = done; rsp = rsp_read_data; lat = c; tmo = timeout_error;
        return;
      end
    end
  endtask

  task automatic wait_strobe(input string name);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_read_request || bus_write_request) return;
    end
    check(name, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_read = '0; req_write = '0; req_address = '0; req_write_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_grant"}, grant, '0);
    check({name, "_done"}, done, '0);
    check({name, "_strobes"}, {bus_read_request, bus_write_request}, '0);
    check({name, "_addr"}, bus_address, '0);
    check({name, "_wdata"}, bus_write_data, '0);
    check({name, "_rsp"}, rsp_read_data, '0);
    check({name, "_tmo"}, timeout_error, '0);
  endtask

  typedef struct {
    int port; logic rd; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    int delay; logic [DW-1:0] rdata;
    int exp_nrd; int exp_nwr; logic [N-1:0] exp_done; int exp_lat; logic [DW-1:0] exp_rsp;
  } vec_t;

  vec_t vecs[6];

  logic [N-1:0]  dv;
  logic [DW-1:0] rsp, wd;
  logic [AW-1:0] ad;
  int            lat, nrd, nwr, cnt;
  logic          tmo;

  initial begin
    vecs[0] = '{0, 1'b1, 1'b0, 32'hA000_0000, 128'h0, 2, 128'h0011_2233_4455_6677_8899_AABB_DEAD_BEEF,
                1, 0, 4'b0001, 5, 128'h0011_2233_4455_6677_8899_AABB_DEAD_BEEF};
    vecs[1] = '{2, 1'b0, 1'b1, 32'hB100_0000, 128'hDEAD_BEEF, 0, 128'h0,
                0, 1, 4'b0100, 3, 128'h0};
    vecs[2] = '{1, 1'b1, 1'b1, 32'h1234_5670, 128'hCAFE, 1, 128'h77,
                0, 1, 4'b0010, 4, 128'h77};
    vecs[3] = '{3, 1'b1, 1'b0, 32'hFFFF_FFFC, 128'h5, 4, {128{1'b1}},
                1, 0, 4'b1000, 7, {128{1'b1}}};
    vecs[4] = '{0, 1'b0, 1'b1, 32'h0, {128{1'b1}}, 3, 128'h1,
                0, 1, 4'b0001, 6, 128'h1};
    vecs[5] = '{3, 1'b1, 1'b0, 32'h8000_0000, 128'h9, 0, 128'hABCD,
                1, 0, 4'b1000, 3, 128'hABCD};

    do_reset();
    check_all_zero("reset");
    resp_en = 1'b1;

    // Single-transaction vectors.
    for (int i = 0; i < 6; i++) begin
      resp_delay = vecs[i].delay;
      resp_data  = vecs[i].rdata;
      set_port(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_done(40, dv, rsp, lat, nrd, nwr, ad, wd, tmo);
      set_port(vecs[i].port, 1'b0, 1'b0, '0, '0);
      check($sformatf("v%0d_done", i), dv, vecs[i].exp_done);
      check($sformatf("v%0d_rd_pulses", i), nrd, vecs[i].exp_nrd);
      check($sformatf("v%0d_wr_pulses", i), nwr, vecs[i].exp_nwr);
      check($sformatf("v%0d_bus_addr", i), ad, vecs[i].addr);
      check($sformatf("v%0d_bus_wdata", i), wd, vecs[i].wdata);
      check($sformatf("v%0d_rsp", i), rsp, vecs[i].exp_rsp);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), {grant, done}, '0);
    end

    // All four ports request straight out of reset: served 0,1,2,3.
    do_reset();
    resp_delay = 0;
    for (int p = 0; p < int'(N); p++) set_port(p, 1'b1, 1'b0, AW'(32'hC000_0000 + p), '0);
    for (int k = 0; k < int'(N); k++) begin
      wait_done(40, dv, rsp, lat, nrd, nwr, ad, wd, tmo);
      check($sformatf("rr_order_%0d", k), dv, onehot(k));
      check($sformatf("rr_addr_%0d", k), ad, AW'(32'hC000_0000 + k));
      for (int p = 0; p < int'(N); p++) if (dv[p]) set_port(p, 1'b0, 1'b0, '0, '0);
    end

    // Port 1 holds its request; port 3 arrives mid-WAIT and must go next.
    resp_delay = 2;
    resp_data  = 128'h1111;
    set_port(1, 1'b1, 1'b0, 32'h0000_1000, '0);
    wait_strobe("p1_strobe_timeout");
    @(negedge clk);
    set_port(3, 1'b1, 1'b0, 32'h0000_3000, '0);
    wait_done(40, dv, rsp, lat, nrd, nwr, ad, wd, tmo);
    check("fair_first", dv, 4'b0010);
    wait_done(40, dv, rsp, lat, nrd, nwr, ad, wd, tmo);
    check("fair_second", dv, 4'b1000);
    set_port(3, 1'b0, 1'b0, '0, '0);
    wait_done(40, dv, rsp, lat, nrd, nwr, ad, wd, tmo);
    check("fair_third", dv, 4'b0010);
    set_port(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // bus_ready outside WAIT is ignored.
    resp_en = 1'b0;
    resp_data = 128'h2222;
    force_ready = 1'b1;
    set_port(2, 1'b1, 1'b0, 32'h0000_2000, '0);
    @(negedge clk);
    force_ready = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done != '0) cnt++;
    end
    check("early_ready_ignored", cnt, 0);
    force_ready = 1'b1;
    wait_done(10, dv, rsp, lat, nrd, nwr, ad, wd, tmo);
    force_ready = 1'b0;
    set_port(2, 1'b0, 1'b0, '0, '0);
    check("late_ready_done", dv, 4'b0100);
    check("late_ready_rsp", rsp, 128'h2222);
    @(negedge clk);

    // Reset during WAIT abandons the transaction.
    set_port(0, 1'b1, 1'b0, 32'h0000_0ABC, 128'h5A);
    wait_strobe("rst_strobe_timeout");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    set_port(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done != '0 || bus_read_request || bus_write_request) cnt++;
    end
    check("after_reset_quiet", cnt, 0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog abort with no bus_ready at all.
    set_port(1, 1'b0, 1'b1, 32'h0000_7000, 128'h7);
    wait_strobe("tmo_strobe_timeout");
    cnt = 0;
    for (int c = 1; c <= 4 * int'(TMO); c++) begin
      @(negedge clk);
      if (done != '0) begin
        cnt = c;
        dv = done; tmo = timeout_error; rsp = rsp_read_data;
        break;
      end
    end
    set_port(1, 1'b0, 1'b0, '0, '0);
    check("tmo_latency", cnt, TMO + 1);
    check("tmo_done", dv, 4'b0010);
    check("tmo_flag", tmo, 1'b1);
    check("tmo_rsp", rsp, '0);
    @(negedge clk);
    check("tmo_pulse_end", {timeout_error, done}, '0);
`else
    check("tmo_tied_low", timeout_error, 1'b0);
`endif

    // Randomized traffic against the round-robin model.
    begin
      logic [N-1:0]  pend, prev_grant;
      logic [AW-1:0] m_addr[N];
      logic [DW-1:0] m_wdata[N];
      logic          m_wr[N];
      int            last_g, cur, completed, op;
      do_reset();
      resp_en = 1'b1;
      pend = '0; prev_grant = '0; last_g = int'(N) - 1; cur = -1; completed = 0;
      for (int p = 0; p < int'(N); p++) begin
        m_addr[p] = '0; m_wdata[p] = '0; m_wr[p] = 1'b0;
      end
      for (int c = 0; c < 6000 && completed < 40; c++) begin
        @(negedge clk);
        if (grant != '0 && prev_grant == '0) begin
          cur = rr_pick(pend, last_g);
          check("rand_grant", grant, onehot(cur));
        end
        if ((bus_read_request || bus_write_request) && cur >= 0) begin
          check("rand_op", {bus_write_request, bus_read_request}, m_wr[cur] ? 2'b10 : 2'b01);
          check("rand_addr", bus_address, m_addr[cur]);
          check("rand_wdata", bus_write_data, m_wdata[cur]);
        end
        if (done != '0) begin
          check("rand_done", done, onehot(cur));
          check("rand_rsp", rsp_read_data, resp_data);
          if (cur >= 0) begin
            pend[cur] = 1'b0;
            set_port(cur, 1'b0, 1'b0, '0, '0);
            last_g = cur;
          end
          cur = -1;
          completed++;
          resp_delay = int'($urandom_range(0, 3));
          resp_data  = {$urandom, $urandom, $urandom, $urandom};
        end else if (cur >= 0) begin
          // Granted port changes its payload; the latched values must stay on the bus.
          req_address[cur*AW +: AW] = $urandom;
          req_write_data[cur*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        end
        prev_grant = grant;
        for (int p = 0; p < int'(N); p++) begin
          if (!pend[p] && $urandom_range(0, 3) == 0) begin
            op = int'($urandom_range(0, 2));
            m_wr[p]    = (op != 0);
            m_addr[p]  = $urandom;
            m_wdata[p] = {$urandom, $urandom, $urandom, $urandom};
            pend[p]    = 1'b1;
            set_port(p, op != 1, op != 0, m_addr[p], m_wdata[p]);
          end
        end
      end
      check("rand_completed", completed, 40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
